// File: rtl/lru_pkg.sv
// Shared types and sizing for the L1 LRU bit-array controller.
package lru_pkg;

  localparam int NUM_SETS = 8;
  localparam int IX_W     = $clog2(NUM_SETS);

  typedef enum logic [1:0] {
    SWEEP  = 2'd0,
    IDLE   = 2'd1,
    LOOKUP = 2'd2,
    UPDATE = 2'd3
  } lru_state_t;

endpackage

// File: rtl/lru_ctrl_if.sv
// Cache-controller request bundle and L-array port bundle for lru_ctrl.
interface lru_ctrl_if;
  import lru_pkg::*;

  logic            flush;
  logic            req;
  logic [IX_W-1:0] set_ix;
  logic            miss;
  logic            hit_way;
  logic            ack;
  logic            victim_way;
  logic            busy;

  modport master (
    output flush, req, set_ix, miss, hit_way,
    input  ack, victim_way, busy
  );

  modport slave (
    input  flush, req, set_ix, miss, hit_way,
    output ack, victim_way, busy
  );
endinterface

interface lru_arr_if;
  import lru_pkg::*;

  logic            arr_we;
  logic [IX_W-1:0] arr_ix;
  logic            arr_din;
  logic            arr_dout;

  modport master (
    output arr_we, arr_ix, arr_din,
    input  arr_dout
  );

  modport slave (
    input  arr_we, arr_ix, arr_din,
    output arr_dout
  );
endinterface

// File: rtl/lru_ctrl.sv
// Write-side controller for the 2-way L1 LRU bit array:
// clears it after reset/flush and runs read-victim / write-back accesses.
module lru_ctrl
  import lru_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  lru_ctrl_if.slave cif,
  lru_arr_if.master aif
);

  lru_state_t      state;
  logic [IX_W-1:0] cnt;
  logic [IX_W-1:0] ix_q;
  logic            miss_q;
  logic            way_q;
  logic            victim_q;
  logic            flush_pend;
  logic            last;

  logic            we;
  logic [IX_W-1:0] ix;
  logic            din;
  logic            ack;
  logic            busy;

  assign last = (cnt == IX_W'(NUM_SETS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SWEEP;
      cnt        <= '0;
      ix_q       <= '0;
      miss_q     <= 1'b0;
      way_q      <= 1'b0;
      victim_q   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        SWEEP: begin
          if (cif.flush) begin
            cnt <= '0;
          end else if (last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          // a pending flush beats a waiting request
          if (cif.flush || flush_pend) begin
            flush_pend <= 1'b0;
            cnt        <= '0;
            state      <= SWEEP;
          end else if (cif.req) begin
            ix_q   <= cif.set_ix;
            miss_q <= cif.miss;
            way_q  <= cif.hit_way;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          victim_q <= aif.arr_dout;
          state    <= UPDATE;
          if (cif.flush) flush_pend <= 1'b1;
        end
        UPDATE: begin
          state <= IDLE;
          if (cif.flush) flush_pend <= 1'b1;
        end
        default: state <= SWEEP;
      endcase
    end
  end

  always_comb begin
    we   = 1'b0;
    ix   = ix_q;
    din  = 1'b0;
    ack  = 1'b0;
    busy = 1'b0;
    unique case (1'b1)
      (state == SWEEP): begin
        we   = 1'b1;
        ix   = cnt;
        busy = 1'b1;
      end
      (state == UPDATE): begin
        // L names the LRU way: the other one from the way just used
        we  = 1'b1;
        ack = 1'b1;
        din = miss_q ? ~victim_q : ~way_q;
      end
      default: ;
    endcase
  end

  assign aif.arr_we     = we;
  assign aif.arr_ix     = ix;
  assign aif.arr_din    = din;
  assign cif.ack        = ack;
  assign cif.busy       = busy;
  assign cif.victim_way = victim_q;

endmodule

// File: tb/tb_lru_ctrl.sv
// Scoreboard bench for lru_ctrl with a behavioural L-bit model
// and a simple storage model of the external L array.
module tb_lru_ctrl;
  import lru_pkg::*;

  logic clk = 1'b0;
  logic rst;

  lru_ctrl_if cif ();
  lru_arr_if  aif ();

  lru_ctrl dut (
    .clk (clk),
    .rst (rst),
    .cif (cif.slave),
    .aif (aif.master)
  );

  always #5 clk = ~clk;

  logic [NUM_SETS-1:0] arr = 8'b1011_0110;
  assign aif.arr_dout = arr[aif.arr_ix];
  always @(posedge clk)
    if (aif.arr_we) arr[aif.arr_ix] <= aif.arr_din;

  bit [NUM_SETS-1:0] model;
  bit exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cif.ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=1 expected ack=0");
      end else begin
        chk("victim_way", int'(cif.victim_way), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_array(input string nm);
    chk(nm, int'(arr), int'(model));
  endtask

  task automatic check_sweep();
    for (int k = 1; k <= NUM_SETS; k++) begin
      @(negedge clk);
      if (k < NUM_SETS) begin
        chk("sweep_ix", int'(aif.arr_ix), k);
        chk("sweep_busy", int'(cif.busy), 1);
      end else begin
        chk("sweep_end_busy", int'(cif.busy), 0);
      end
    end
  endtask

  task automatic wait_sweep();
    int k;
    k = 0;
    while (!cif.busy && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("sweep_start", int'(cif.busy), 1);
    k = 0;
    while (cif.busy && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk("sweep_done", int'(cif.busy), 0);
  endtask

  // Called at a negedge in an IDLE cycle; returns one negedge after ack.
  task automatic access(input int s, input bit m, input bit w,
                        input int lat, input bit fl_lookup,
                        input bit fl_with);
    int k;
    bit seen;
    bit old;
    if (fl_with) model = '0;
    old = model[s];
    exp_q.push_back(old);
    model[s] = m ? ~old : ~w;
    if (fl_lookup) model = '0;
    cif.req     = 1'b1;
    cif.set_ix  = IX_W'(s);
    cif.miss    = m;
    cif.hit_way = w;
    cif.flush   = fl_with;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      cif.flush = (k == 1) ? fl_lookup : 1'b0;
      if (cif.ack) seen = 1'b1;
    end
    cif.req   = 1'b0;
    cif.flush = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got no ack expected ack within 40");
      void'(exp_q.pop_back());
    end else begin
      chk("latency", k, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    cif.flush   = 1'b0;
    cif.req     = 1'b0;
    cif.set_ix  = '0;
    cif.miss    = 1'b0;
    cif.hit_way = 1'b0;
    model       = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", int'(cif.ack), 0);
    chk("rst_busy", int'(cif.busy), 1);
    chk("rst_victim", int'(cif.victim_way), 0);
    chk("rst_we", int'(aif.arr_we), 1);
    chk("rst_ix", int'(aif.arr_ix), 0);
    chk("rst_din", int'(aif.arr_din), 0);
    rst = 1'b0;
    check_sweep();
    check_array("array_after_reset");

    access(3, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    check_array("array_hit3");
    access(3, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check_array("array_miss3");

    access(5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    access(5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check_array("array_miss5x2");

    access(6, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    access(2, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    wait_sweep();
    check_array("array_flush_lookup");

    access(0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    access(7, 1'b1, 1'b0, 11, 1'b0, 1'b1);
    check_array("array_flush_with_req");

    cif.flush = 1'b1;
    @(negedge clk);
    cif.flush = 1'b0;
    chk("flush_busy", int'(cif.busy), 1);
    chk("flush_ix0", int'(aif.arr_ix), 0);
    repeat (3) @(negedge clk);
    chk("flush_ix3", int'(aif.arr_ix), 3);
    cif.flush = 1'b1;
    @(negedge clk);
    cif.flush = 1'b0;
    chk("restart_ix0", int'(aif.arr_ix), 0);
    model = '0;
    check_sweep();
    check_array("array_flush_restart");

    access(4, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    cif.req     = 1'b1;
    cif.set_ix  = IX_W'(4);
    cif.miss    = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    cif.req = 1'b0;
    model   = '0;
    chk("rst_mid_ack", int'(cif.ack), 0);
    chk("rst_mid_we", int'(aif.arr_we), 1);
    chk("rst_mid_ix", int'(aif.arr_ix), 0);
    chk("rst_mid_busy", int'(cif.busy), 1);
    check_sweep();
    check_array("array_rst_mid");

    for (int i = 0; i < 40; i++) begin
      int s;
      bit m, w, fl, fw;
      s  = $urandom_range(0, NUM_SETS - 1);
      m  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      fw = ($urandom_range(0, 7) == 0);
      fl = !fw && ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(s, m, w, fw ? 11 : 2, fl, fw);
      if (fl) wait_sweep();
    end
    check_array("array_random");
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
